// File: rtl/poci_arb_pkg.sv
// Shared types and the round-robin pick function for the POCI arbiter.
package poci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int MAX_NM = 8;

  // Returns {valid, index}: the first set bit of req strictly after 'last', wrapping modulo nm.
  function automatic logic [3:0] rr_pick(input logic [MAX_NM-1:0] req,
                                         input logic [2:0]        last,
                                         input int                nm);
    logic [3:0] pick;
    int         idx;
    pick = '0;
    // Scan from farthest to nearest so the nearest requester overwrites earlier hits.
    for (int k = MAX_NM; k >= 1; k--) begin
      if (k <= nm) begin
        idx = (int'(last) + k) % nm;
        if (req[idx]) pick = {1'b1, 3'(idx)};
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/poci_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after 'last'.
module rr_arbiter
  import poci_arb_pkg::*;
#(
  parameter int NM = 2,
  localparam int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] onehot,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [MAX_NM-1:0] req_ext;
  logic [3:0]        pick;

  always_comb begin
    req_ext          = '0;
    req_ext[NM-1:0]  = req;
    pick             = rr_pick(req_ext, 3'(last), NM);
    valid            = pick[3];
    index            = pick[IW-1:0];
    onehot           = '0;
    if (pick[3]) onehot = NM'(1) << index;
  end

endmodule

// File: rtl/poci_arbiter.sv
// Shares one POCI slave between NM masters with per-transfer round-robin grant,
// regenerated setup/access phases and an optional watchdog on hung slave accesses.
module poci_arbiter
  import poci_arb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  localparam int IW     = $clog2(NM)
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [NM-1:0]    m_psel,
  input  logic [NM-1:0]    m_penable,
  input  logic [NM-1:0]    m_pwrite,
  input  logic [NM*AW-1:0] m_paddr,
  input  logic [NM*DW-1:0] m_pwdata,
  output logic [DW-1:0]    m_prdata,
  output logic [NM-1:0]    m_pready,
  output logic [NM-1:0]    m_pslverr,
  output logic             s_psel,
  output logic             s_penable,
  output logic             s_pwrite,
  output logic [AW-1:0]    s_paddr,
  output logic [DW-1:0]    s_pwdata,
  input  logic [DW-1:0]    s_prdata,
  input  logic             s_pready,
  input  logic             s_pslverr,
  output arb_state_e       dbg_state,
  output logic [IW-1:0]    dbg_last
);

  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  // Handshake: a master's request (m_psel) stays asserted with stable attributes until
  // the single cycle in which its m_pready is high; that cycle is the completion.

  arb_state_e     state;
  logic [IW-1:0]  grant;
  logic [IW-1:0]  last;
  logic [WW-1:0]  wdog;

  logic [NM-1:0]  grant_oh;
  logic [NM-1:0]  idle_oh;
  logic [IW-1:0]  idle_index;
  logic           idle_valid;
  logic [NM-1:0]  next_oh;
  logic [IW-1:0]  next_index;
  logic           next_valid;
  logic           timeout_hit;
  logic           done;
  logic           unused_penable;

  // The masters' own enable is irrelevant: the slave phase is rebuilt here.
  assign unused_penable = ^m_penable;

  assign grant_oh = NM'(1) << grant;

  rr_arbiter #(.NM(NM)) u_rr_idle (
    .req    (m_psel),
    .last   (last),
    .onehot (idle_oh),
    .index  (idle_index),
    .valid  (idle_valid)
  );

  // Back-to-back pick excludes the master completing this cycle.
  rr_arbiter #(.NM(NM)) u_rr_next (
    .req    (m_psel & ~grant_oh),
    .last   (grant),
    .onehot (next_oh),
    .index  (next_index),
    .valid  (next_valid)
  );

  assign timeout_hit = (TIMEOUT != 0) && (wdog == WD_LAST) && !s_pready;
  assign done        = (state == ACCESS) && !preset && (s_pready || timeout_hit);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(NM - 1);
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_valid) begin
            grant <= idle_index;
            state <= SETUP;
          end
        end
        SETUP: begin
          wdog  <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            last <= grant;
            if (next_valid) begin
              grant <= next_index;
              state <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else if (!s_pready && (wdog != '1)) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_psel    = (state == SETUP) || (state == ACCESS);
    s_penable = (state == ACCESS);
    s_pwrite  = m_pwrite[grant];
    s_paddr   = m_paddr[int'(grant)*AW +: AW];
    s_pwdata  = m_pwdata[int'(grant)*DW +: DW];
    m_prdata  = s_prdata;
    m_pready  = done ? grant_oh : '0;
    m_pslverr = (done && (!s_pready || s_pslverr)) ? grant_oh : '0;
  end

  assign dbg_state = state;
  assign dbg_last  = last;

endmodule

// File: tb/tb_poci_arbiter.sv
// Self-checking bench for poci_arbiter: scenario tasks plus an in-order completion scoreboard.
module tb_poci_arbiter;
  import poci_arb_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 3 + 1 + 1 + AW + DW;

  logic             pclk = 1'b0;
  logic             preset = 1'b1;
  logic [NM-1:0]    m_psel = '0;
  logic [NM-1:0]    m_penable = '0;
  logic [NM-1:0]    m_pwrite = '0;
  logic [NM*AW-1:0] m_paddr = '0;
  logic [NM*DW-1:0] m_pwdata = '0;
  logic [DW-1:0]    m_prdata;
  logic [NM-1:0]    m_pready;
  logic [NM-1:0]    m_pslverr;
  logic             s_psel;
  logic             s_penable;
  logic             s_pwrite;
  logic [AW-1:0]    s_paddr;
  logic [DW-1:0]    s_pwdata;
  logic [DW-1:0]    s_prdata = '0;
  logic             s_pready = 1'b0;
  logic             s_pslverr = 1'b0;
  arb_state_e       dbg_state;
  logic [0:0]       dbg_last;

  logic [DW-1:0]    d0_m_prdata;
  logic [NM-1:0]    d0_m_pready;
  logic [NM-1:0]    d0_m_pslverr;
  logic             d0_s_psel;
  logic             d0_s_penable;
  logic             d0_s_pwrite;
  logic [AW-1:0]    d0_s_paddr;
  logic [DW-1:0]    d0_s_pwdata;
  arb_state_e       d0_dbg_state;
  logic [0:0]       d0_dbg_last;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int          slave_wait  = 0;
  bit          slave_stuck = 1'b0;
  logic        slave_err   = 1'b0;
  logic [DW-1:0] slave_rdata = '0;
  int          acc_cnt     = 0;

  poci_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8)) u_dut (
    .pclk(pclk), .preset(preset), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr),
    .dbg_state(dbg_state), .dbg_last(dbg_last)
  );

  // Watchdog-disabled twin sharing all inputs.
  poci_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_prdata(d0_m_prdata), .m_pready(d0_m_pready), .m_pslverr(d0_m_pslverr),
    .s_psel(d0_s_psel), .s_penable(d0_s_penable), .s_pwrite(d0_s_pwrite),
    .s_paddr(d0_s_paddr), .s_pwdata(d0_s_pwdata), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr),
    .dbg_state(d0_dbg_state), .dbg_last(d0_dbg_last)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  // Slave model: ready after slave_wait extra ACCESS cycles unless stuck.
  always @(posedge pclk) begin
    #1;
    if (s_penable) acc_cnt++;
    else acc_cnt = 0;
    s_pready  = s_penable && !slave_stuck && (acc_cnt > slave_wait);
    s_pslverr = s_pready && slave_err;
    s_prdata  = slave_rdata;
  end

  // Scoreboard: every completion must match the oldest expected transfer.
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  int           mon_idx;
  always @(negedge pclk) begin
    if (m_pready != 0 || m_pslverr != 0) begin
      checks++;
      if ($countones(m_pready) != 1 || (m_pslverr & ~m_pready) != 0) begin
        errors++;
        $display("FAIL pready_onehot: m_pready=%b m_pslverr=%b, required exactly one ready bit covering any error",
                 m_pready, m_pslverr);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready: m_pready=%b with no transfer expected", m_pready);
      end else begin
        mon_idx = m_pready[1] ? 1 : 0;
        mon_got = {3'(mon_idx), s_pwrite, m_pslverr[mon_idx], s_paddr, s_pwrite ? s_pwdata : m_prdata};
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard: got {mst,wr,err,addr,data}=%h required %h", mon_got, mon_exp);
        end
      end
    end
  end

  // Driver: present a request on master idx and optionally record its expected completion.
  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic err, input bit push);
    m_pwrite[idx]             = wr;
    m_paddr[idx*AW +: AW]     = addr;
    m_pwdata[idx*DW +: DW]    = data;
    m_psel[idx]               = 1'b1;
    if (push) exp_q.push_back({3'(idx), wr, err, addr, wr ? data : slave_rdata});
  endtask

  // Driver: hold requests until each master's own m_pready, dropping psel after it.
  task automatic serve(input int budget);
    int            n;
    logic [NM-1:0] done;
    bit            prev_other;
    n = 0;
    prev_other = 1'b0;
    while (m_psel != 0 && n < budget) begin
      @(negedge pclk);
      done = m_pready & m_psel;
      if (prev_other) begin
        checks++;
        if (!(s_psel && !s_penable)) begin
          errors++;
          $display("FAIL b2b_setup: s_psel=%b s_penable=%b, required 1/0 right after completion",
                   s_psel, s_penable);
        end
      end
      prev_other = (done != 0) && ((m_psel & ~done) != 0);
      @(posedge pclk);
      #1;
      m_psel = m_psel & ~done;
      n++;
    end
    checks++;
    if (m_psel != 0) begin
      errors++;
      $display("FAIL serve_timeout: m_psel=%b still pending, required all served", m_psel);
      m_psel = '0;
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    slave_rdata = 32'h0000_0055;
    set_req(0, 1'b1, 32'h0000_0040, 32'h0000_00C3, 1'b0, 1'b1);
    set_req(1, 1'b0, 32'h0000_0044, '0, 1'b0, 1'b1);
    repeat (3) begin
      @(posedge pclk);
      @(negedge pclk);
      checks++;
      if (s_psel !== 1'b0 || m_pready !== 2'b00 || dbg_state !== IDLE) begin
        errors++;
        $display("FAIL reset_hold: s_psel=%b m_pready=%b state=%0d, required 0/00/IDLE",
                 s_psel, m_pready, dbg_state);
      end
    end
    checks++;
    if (dbg_last !== 1'b1) begin
      errors++;
      $display("FAIL reset_last: last=%0d required 1", dbg_last);
    end
    @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if (!(s_psel && !s_penable) || s_paddr !== 32'h0000_0040) begin
      errors++;
      $display("FAIL first_grant_m0: s_psel=%b s_penable=%b s_paddr=%h, required SETUP at 00000040",
               s_psel, s_penable, s_paddr);
    end
    serve(20);
  endtask

  task automatic test_contention();
    for (int r = 0; r < 4; r++) begin
      @(posedge pclk);
      #1;
      slave_err   = (r == 2);
      slave_rdata = 32'h0000_1000 + 32'(r);
      set_req(0, 1'b1, 32'h0000_0100 + 32'(r), 32'h0000_AA00 + 32'(r), slave_err, 1'b1);
      set_req(1, 1'b0, 32'h0000_0200 + 32'(r), '0, slave_err, 1'b1);
      serve(20);
    end
    slave_err = 1'b0;
  endtask

  task automatic test_single_write();
    @(posedge pclk);
    #1;
    set_req(0, 1'b1, 32'h0000_0010, 32'h0000_00A5, 1'b0, 1'b1);
    @(negedge pclk);
    checks++;
    if (s_psel !== 1'b0 || m_pready !== 2'b00) begin
      errors++;
      $display("FAIL sw_idle: s_psel=%b m_pready=%b, required 0/00", s_psel, m_pready);
    end
    @(negedge pclk);
    checks++;
    if (!(s_psel && !s_penable) || m_pready !== 2'b00 || s_paddr !== 32'h10 || s_pwdata !== 32'hA5) begin
      errors++;
      $display("FAIL sw_setup: psel=%b pen=%b rdy=%b addr=%h data=%h, required 1/0/00/10/A5",
               s_psel, s_penable, m_pready, s_paddr, s_pwdata);
    end
    @(negedge pclk);
    checks++;
    if (!(s_psel && s_penable) || m_pready !== 2'b01) begin
      errors++;
      $display("FAIL sw_access: psel=%b pen=%b m_pready=%b, required 1/1/01", s_psel, s_penable, m_pready);
    end
    @(posedge pclk);
    #1;
    m_psel[0] = 1'b0;
    @(negedge pclk);
    checks++;
    if (s_psel !== 1'b0 || m_pready !== 2'b00) begin
      errors++;
      $display("FAIL sw_after: s_psel=%b m_pready=%b, required 0/00", s_psel, m_pready);
    end
  endtask

  task automatic test_read_wait();
    int acc;
    int n;
    bit got;
    @(posedge pclk);
    #1;
    slave_wait  = 3;
    slave_rdata = 32'h0000_03FF;
    set_req(1, 1'b0, 32'h0000_0020, '0, 1'b0, 1'b1);
    acc = 0;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge pclk);
      n++;
      if (s_psel) begin
        checks++;
        if (s_paddr !== 32'h0000_0020 || s_pwrite !== 1'b0) begin
          errors++;
          $display("FAIL read_stable: s_paddr=%h s_pwrite=%b, required 00000020/0", s_paddr, s_pwrite);
        end
      end
      if (s_penable) acc++;
      if (m_pready[1]) begin
        got = 1'b1;
        checks++;
        if (acc != 4 || m_prdata !== 32'h0000_03FF) begin
          errors++;
          $display("FAIL read_wait: ready after %0d ACCESS cycles, prdata=%h, required 4 and 000003FF",
                   acc, m_prdata);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL read_timeout: no m_pready[1] within 20 cycles, required completion");
    end
    @(posedge pclk);
    #1;
    m_psel[1]  = 1'b0;
    slave_wait = 0;
  endtask

  task automatic test_reset_mid_access();
    int acc;
    int n;
    @(posedge pclk);
    #1;
    set_req(0, 1'b1, 32'h0000_0050, 32'h0000_0011, 1'b0, 1'b1);
    serve(20);
    slave_wait = 10;
    set_req(1, 1'b0, 32'h0000_0054, '0, 1'b0, 1'b0);
    acc = 0;
    n = 0;
    while (acc < 2 && n < 20) begin
      @(negedge pclk);
      n++;
      if (s_penable) acc++;
    end
    checks++;
    if (acc < 2) begin
      errors++;
      $display("FAIL midrst_reach: %0d ACCESS cycles seen, required 2", acc);
    end
    @(posedge pclk);
    #1;
    preset = 1'b1;
    @(negedge pclk);
    checks++;
    if (m_pready !== 2'b00) begin
      errors++;
      $display("FAIL midrst_same: m_pready=%b required 00", m_pready);
    end
    @(negedge pclk);
    checks++;
    if (s_psel !== 1'b0 || m_pready !== 2'b00 || dbg_last !== 1'b1 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL midrst_after: s_psel=%b m_pready=%b last=%0d state=%0d, required 0/00/1/IDLE",
               s_psel, m_pready, dbg_last, dbg_state);
    end
    @(posedge pclk);
    #1;
    preset     = 1'b0;
    m_psel     = '0;
    slave_wait = 0;
  endtask

  task automatic test_watchdog();
    int acc;
    int n;
    bit got;
    bit d0_bad;
    @(posedge pclk);
    #1;
    slave_stuck = 1'b1;
    set_req(0, 1'b1, 32'h0000_0060, 32'h0000_005A, 1'b1, 1'b1);
    acc = 0;
    n = 0;
    got = 1'b0;
    d0_bad = 1'b0;
    while (!got && n < 30) begin
      @(negedge pclk);
      n++;
      if (s_penable) acc++;
      if (d0_m_pready != 0) d0_bad = 1'b1;
      if (m_pready[0]) begin
        got = 1'b1;
        checks++;
        if (acc != 8 || m_pslverr[0] !== 1'b1) begin
          errors++;
          $display("FAIL wd_fire: fired on ACCESS cycle %0d pslverr=%b, required 8 and 1", acc, m_pslverr[0]);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wd_timeout: watchdog did not complete within 30 cycles");
    end
    @(posedge pclk);
    #1;
    m_psel = '0;
    @(negedge pclk);
    checks++;
    if (s_psel !== 1'b0) begin
      errors++;
      $display("FAIL wd_release: s_psel=%b required 0 after forced completion", s_psel);
    end
    repeat (5) begin
      @(negedge pclk);
      if (d0_m_pready != 0) d0_bad = 1'b1;
    end
    checks++;
    if (d0_bad || !(d0_s_psel && d0_s_penable)) begin
      errors++;
      $display("FAIL wd_disabled: completion=%b psel=%b penable=%b, required no completion and still in ACCESS",
               d0_bad, d0_s_psel, d0_s_penable);
    end
    slave_stuck = 1'b0;
    @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_read_wait();
    test_reset_mid_access();
    test_watchdog();
    @(negedge pclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d transfers outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "global timeout");
  end

endmodule
